// File: rtl/plus4_mem_ctrl.sv
// rtl/plus4_mem_ctrl.sv - Plus/4 CPU-side address decode, ROM banking, overlay flag and read capture
module plus4_mem_ctrl #(
  parameter int RAMSIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_end,
  input  logic        aec,
  input  logic [15:0] cpu_address,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_rdata,
  output logic        ted_cs,
  input  logic [7:0]  ted_data,
  output logic        io_cs,
  input  logic [7:0]  io_data
);

  logic [3:0] rom_bank_q, rom_bank_d;
  logic       rom_on_q, rom_on_d;
  logic [7:0] cpu_data_in_q, cpu_data_in_d;

  logic       ted_hit;
  logic       io_hit;
  logic       rom_hit;
  logic       kernal_win;
  logic [1:0] bank_sel;
  logic       bus_wr;
  logic       bus_rd;

  // Region decode: TED and I/O windows shadow ROM; ROM only when the overlay is on
  always_comb begin
    ted_hit    = (cpu_address[15:6] == 10'h3FC);
    io_hit     = (cpu_address[15:8] == 8'hFD) || (cpu_address[15:8] == 8'hFE);
    rom_hit    = cpu_address[15] & ~ted_hit & ~io_hit & rom_on_q;
    kernal_win = (cpu_address[15:8] == 8'hFC);
    if (kernal_win) begin
      bank_sel = 2'b00;
    end else if (cpu_address[14]) begin
      bank_sel = rom_bank_q[3:2];
    end else begin
      bank_sel = rom_bank_q[1:0];
    end
    // The ROM bus is 16 bits wide, so the half select takes bit 13's slot
    rom_addr = {bank_sel, cpu_address[14], cpu_address[12:0]};
    rom_cs   = rom_hit;
    ted_cs   = ted_hit;
    io_cs    = io_hit;
  end

  // RAM address masking mirrors smaller RAM sizes through the 64K map
  always_comb begin
    if (RAMSIZE == 16) begin
      ram_addr = {2'b00, cpu_address[13:0]};
    end else if (RAMSIZE == 32) begin
      ram_addr = {1'b0, cpu_address[14:0]};
    end else begin
      ram_addr = cpu_address;
    end
  end

  // Bus commit qualifiers and the write strobe; writes under ROM fall through to RAM
  always_comb begin
    bus_wr    = ~reset & cycle_end & aec & ~cpu_rw;
    bus_rd    = ~reset & cycle_end & aec & cpu_rw;
    ram_we    = bus_wr & ~ted_hit & ~io_hit;
    ram_wdata = cpu_data_out;
  end

  // Next state for the bank latch, overlay flag and read data register
  always_comb begin
    rom_bank_d    = rom_bank_q;
    rom_on_d      = rom_on_q;
    cpu_data_in_d = cpu_data_in_q;
    if (bus_wr) begin
      if (cpu_address[15:4] == 12'hFDD) begin
        rom_bank_d = cpu_address[3:0];
      end
      if (cpu_address == 16'hFF3E) begin
        rom_on_d = 1'b1;
      end
      if (cpu_address == 16'hFF3F) begin
        rom_on_d = 1'b0;
      end
    end
    if (bus_rd) begin
      if (ted_hit) begin
        cpu_data_in_d = ted_data;
      end else if (io_hit) begin
        cpu_data_in_d = io_data;
      end else if (rom_hit) begin
        cpu_data_in_d = rom_rdata;
      end else begin
        cpu_data_in_d = ram_rdata;
      end
    end
  end

  // State registers with synchronous reset taking priority over any pending commit
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_bank_q    <= 4'h0;
      rom_on_q      <= 1'b1;
      cpu_data_in_q <= 8'hFF;
    end else begin
      rom_bank_q    <= rom_bank_d;
      rom_on_q      <= rom_on_d;
      cpu_data_in_q <= cpu_data_in_d;
    end
  end

  assign cpu_data_in = cpu_data_in_q;

endmodule

// File: tb/tb_plus4_mem_ctrl.sv
// tb/tb_plus4_mem_ctrl.sv - self-checking bench for plus4_mem_ctrl
module tb_plus4_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cycle_end, aec, cpu_rw;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out, ram_rdata, rom_rdata, ted_data, io_data;

  logic [7:0]  din64, din16, wd64, wd16;
  logic [15:0] ra64, ra16, roma64, roma16;
  logic        we64, we16, romcs64, romcs16, tedcs64, tedcs16, iocs64, iocs16;

  plus4_mem_ctrl #(.RAMSIZE(64)) dut (
    .clk(clk), .reset(reset), .cycle_end(cycle_end), .aec(aec),
    .cpu_address(cpu_address), .cpu_rw(cpu_rw), .cpu_data_out(cpu_data_out),
    .cpu_data_in(din64), .ram_addr(ra64), .ram_wdata(wd64), .ram_we(we64),
    .ram_rdata(ram_rdata), .rom_addr(roma64), .rom_cs(romcs64), .rom_rdata(rom_rdata),
    .ted_cs(tedcs64), .ted_data(ted_data), .io_cs(iocs64), .io_data(io_data)
  );

  plus4_mem_ctrl #(.RAMSIZE(16)) dut16 (
    .clk(clk), .reset(reset), .cycle_end(cycle_end), .aec(aec),
    .cpu_address(cpu_address), .cpu_rw(cpu_rw), .cpu_data_out(cpu_data_out),
    .cpu_data_in(din16), .ram_addr(ra16), .ram_wdata(wd16), .ram_we(we16),
    .ram_rdata(ram_rdata), .rom_addr(roma16), .rom_cs(romcs16), .rom_rdata(rom_rdata),
    .ted_cs(tedcs16), .ted_data(ted_data), .io_cs(iocs16), .io_data(io_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (addr %h, t=%0t)", name, act, exp, cpu_address, $time);
    end
  endtask

  function automatic logic [15:0] ram_mask(input logic [15:0] a, input int kb);
    return 16'(int'(a) % (kb * 1024));
  endfunction

  function automatic logic [15:0] rom_map(input logic [15:0] a, input logic [3:0] bank);
    int hi, b, ai;
    ai = int'(a);
    hi = (ai / 16384) % 2;
    if (ai / 256 == 252) b = 0;
    else if (hi == 1)    b = int'(bank) / 4;
    else                 b = int'(bank) % 4;
    return 16'(b * 16384 + hi * 8192 + ai % 8192);
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wd;
    logic        aec;
    logic [7:0]  ramd, romd, tedd, iod;
    logic        e_rom, e_ted, e_io;
    logic [15:0] e_roma;
    logic        e_we;
    logic [7:0]  e_din;
  } vec_t;

  vec_t vecs[19];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cycle_end = 1'b0; cpu_rw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    cpu_address = v.addr; cpu_rw = v.rw; cpu_data_out = v.wd; aec = v.aec;
    ram_rdata = v.ramd; rom_rdata = v.romd; ted_data = v.tedd; io_data = v.iod;
    cycle_end = 1'b1;
    #1;
    chk($sformatf("v%0d rom_cs", i), romcs64, v.e_rom);
    chk($sformatf("v%0d ted_cs", i), tedcs64, v.e_ted);
    chk($sformatf("v%0d io_cs", i), iocs64, v.e_io);
    chk($sformatf("v%0d rom_addr", i), roma64, v.e_roma);
    chk($sformatf("v%0d rom_addr16", i), roma16, v.e_roma);
    chk($sformatf("v%0d ram_we", i), we64, v.e_we);
    chk($sformatf("v%0d ram_we16", i), we16, v.e_we);
    chk($sformatf("v%0d ram_addr", i), ra64, ram_mask(v.addr, 64));
    chk($sformatf("v%0d ram_addr16", i), ra16, ram_mask(v.addr, 16));
    chk($sformatf("v%0d ram_wdata", i), wd16, v.wd);
    @(negedge clk);
    cycle_end = 1'b0;
    #1;
    chk($sformatf("v%0d din", i), din64, v.e_din);
    chk($sformatf("v%0d din16", i), din16, v.e_din);
    chk($sformatf("v%0d we_pulse", i), we64, 1'b0);
  endtask

  logic [3:0]  m_bank;
  logic        m_on;
  logic [7:0]  m_din;

  initial begin
    reset = 1'b1; cycle_end = 1'b0; aec = 1'b1; cpu_rw = 1'b1;
    cpu_address = 16'hFFFF; cpu_data_out = 8'h00;
    ram_rdata = 8'h11; rom_rdata = 8'h22; ted_data = 8'h33; io_data = 8'h44;

    //            addr     rw wd     aec ram    rom    ted    io     rom ted io roma      we din
    vecs[0]  = '{16'hFFFC, 1, 8'h00, 1, 8'h11, 8'h4C, 8'h33, 8'h44, 1, 0, 0, 16'h3FFC, 0, 8'h4C};
    vecs[1]  = '{16'hFF3F, 0, 8'hAA, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 16'h3F3F, 0, 8'h4C};
    vecs[2]  = '{16'h8000, 1, 8'h00, 1, 8'h12, 8'h22, 8'h33, 8'h44, 0, 0, 0, 16'h0000, 0, 8'h12};
    vecs[3]  = '{16'hFF3E, 0, 8'h00, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 16'h3F3E, 0, 8'h12};
    vecs[4]  = '{16'h8000, 1, 8'h00, 1, 8'h12, 8'h77, 8'h33, 8'h44, 1, 0, 0, 16'h0000, 0, 8'h77};
    vecs[5]  = '{16'hFDD5, 0, 8'hC3, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 1, 16'h3DD5, 0, 8'h77};
    vecs[6]  = '{16'h9000, 1, 8'h00, 1, 8'h11, 8'h21, 8'h33, 8'h44, 1, 0, 0, 16'h5000, 0, 8'h21};
    vecs[7]  = '{16'hFC10, 1, 8'h00, 1, 8'h11, 8'h5E, 8'h33, 8'h44, 1, 0, 0, 16'h3C10, 0, 8'h5E};
    vecs[8]  = '{16'hC010, 1, 8'h00, 1, 8'h11, 8'h23, 8'h33, 8'h44, 1, 0, 0, 16'h6010, 0, 8'h23};
    vecs[9]  = '{16'hC123, 0, 8'h55, 1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 16'h6123, 1, 8'h23};
    vecs[10] = '{16'hFF10, 0, 8'h01, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 16'h7F10, 0, 8'h23};
    vecs[11] = '{16'hFE00, 0, 8'h02, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 1, 16'h7E00, 0, 8'h23};
    vecs[12] = '{16'hFF10, 1, 8'h00, 1, 8'h11, 8'h22, 8'h3C, 8'h44, 0, 1, 0, 16'h7F10, 0, 8'h3C};
    vecs[13] = '{16'hFF3F, 0, 8'h00, 0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 16'h7F3F, 0, 8'h3C};
    vecs[14] = '{16'h8000, 1, 8'h00, 1, 8'h11, 8'h5A, 8'h33, 8'h44, 1, 0, 0, 16'h4000, 0, 8'h5A};
    vecs[15] = '{16'h0123, 1, 8'h00, 0, 8'h99, 8'h22, 8'h33, 8'h44, 0, 0, 0, 16'h4123, 0, 8'h5A};
    vecs[16] = '{16'h0001, 0, 8'h0F, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 16'h4001, 1, 8'h5A};
    vecs[17] = '{16'hFE80, 1, 8'h00, 1, 8'h11, 8'h22, 8'h33, 8'h6B, 0, 0, 1, 16'h7E80, 0, 8'h6B};
    vecs[18] = '{16'h4000, 1, 8'h00, 1, 8'h8C, 8'h22, 8'h33, 8'h44, 0, 0, 0, 16'h6000, 0, 8'h8C};

    do_reset();
    #1;
    chk("reset din", din64, 8'hFF);
    chk("reset din16", din16, 8'hFF);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Overlay off, then reset with a read commit in the same clk: reset wins
    run_vec(100, '{16'hFF3F, 0, 8'h00, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 16'h7F3F, 0, 8'h8C});
    @(negedge clk);
    cpu_address = 16'h0200; cpu_rw = 1'b0; cpu_data_out = 8'h77; aec = 1'b1;
    cycle_end = 1'b1; reset = 1'b1;
    #1;
    chk("reset we mask", we64, 1'b0);
    @(negedge clk);
    cpu_rw = 1'b1; ram_rdata = 8'h55;
    @(negedge clk);
    #1;
    chk("reset+ce din", din64, 8'hFF);
    reset = 1'b0; cycle_end = 1'b0;
    cpu_address = 16'h9000;
    #1;
    chk("reset rom_on", romcs64, 1'b1);
    chk("reset bank", roma64, 16'h1000);

    // Randomized traffic against the address-map model
    do_reset();
    m_bank = 4'h0; m_on = 1'b1; m_din = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic        rw, ae, ce, e_ted, e_io, e_rom, e_we;
      int          r;
      r = $urandom_range(0, 5);
      case (r)
        0: a = 16'($urandom_range(16'h0000, 16'h7FFF));
        1: a = 16'($urandom_range(16'h8000, 16'hFCFF));
        2: a = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFDD0, 16'hFDDF))
                                           : 16'($urandom_range(16'hFD00, 16'hFEFF));
        3: a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'hFF3E, 16'hFF3F))
                                           : 16'($urandom_range(16'hFF00, 16'hFF3F));
        4: a = 16'($urandom_range(16'hFF40, 16'hFFFF));
        default: a = 16'($urandom);
      endcase
      rw = 1'($urandom);
      ae = ($urandom_range(0, 7) != 0);
      ce = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cpu_address = a; cpu_rw = rw; aec = ae; cycle_end = ce;
      cpu_data_out = 8'($urandom); ram_rdata = 8'($urandom); rom_rdata = 8'($urandom);
      ted_data = 8'($urandom); io_data = 8'($urandom);
      e_ted = (a >= 16'hFF00) && (a <= 16'hFF3F);
      e_io  = (a >= 16'hFD00) && (a <= 16'hFEFF);
      e_rom = m_on && (a >= 16'h8000) && !e_ted && !e_io;
      e_we  = ce && ae && !rw && !((a >= 16'hFD00) && (a <= 16'hFF3F));
      #1;
      chk("rnd ted_cs", tedcs64, e_ted);
      chk("rnd io_cs", iocs64, e_io);
      chk("rnd rom_cs", romcs64, e_rom);
      chk("rnd rom_addr", roma64, rom_map(a, m_bank));
      chk("rnd ram_addr", ra64, ram_mask(a, 64));
      chk("rnd ram_addr16", ra16, ram_mask(a, 16));
      chk("rnd ram_we", we64, e_we);
      chk("rnd ram_wdata", wd64, cpu_data_out);
      if (ce && ae) begin
        if (!rw) begin
          if (a >= 16'hFDD0 && a <= 16'hFDDF) m_bank = a[3:0];
          if (a == 16'hFF3E) m_on = 1'b1;
          if (a == 16'hFF3F) m_on = 1'b0;
        end else begin
          if (e_ted)      m_din = ted_data;
          else if (e_io)  m_din = io_data;
          else if (e_rom) m_din = rom_rdata;
          else            m_din = ram_rdata;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd din", din64, m_din);
      chk("rnd din16", din16, m_din);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
